m10k_fifo: RTL
==============

# m10k_fifo

Parametrised synchronous FIFO built on a single M10K simple-dual-port RAM with registered, first-word-fall-through output and valid/ready handshakes on both sides. It buffers words between the HPS bridge side and FPGA-side consumers in the same clock domain. It supersedes fixed-size raw RAM instances wherever ordered streaming buffering is needed. Width, depth and the almost-full/almost-empty thresholds are set per instance.

## Interface
Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 8, RAM address width; FIFO capacity DEPTH = 2^ADDR_W words
- AF_THRESH, 2^ADDR_W - 4, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous flush, same effect as reset on FIFO state
- in_data  in  DATA_W  write word
- in_valid  in  1  write request
- in_ready  out  1  FIFO can accept a word this cycle
- out_data  out  DATA_W  head word, valid when out_valid
- out_valid  out  1  head word present
- out_ready  in  1  consumer takes head word this cycle
- count  out  ADDR_W+1  words held (RAM plus output stage), 0..DEPTH
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH

## Operation
- Push: in_valid && in_ready at a rising edge writes in_data to mem[wr_ptr]; wr_ptr increments mod DEPTH.
- Pop: out_valid && out_ready at a rising edge consumes the head word.
- The RAM read port has a read enable. rd_en = (ram_count != 0) && (!out_valid || out_ready). The RAM q register is the output stage: on rd_en, q <= mem[rd_ptr], rd_ptr increments and out_valid <= 1. On a pop without rd_en, out_valid <= 0. Otherwise q and out_valid hold, so out_data is stable while stalled.
- ram_count tracks words in RAM only. It increments on push, decrements on rd_en, and is unchanged when both occur.
- count increments on push and decrements on pop. It is unchanged when both occur.
- in_ready = (count != DEPTH). It is a function of registered state only, with no combinational path from out_ready. A full FIFO with a simultaneous pop still refuses the write that cycle.
- in_valid while !in_ready is back-pressure, not an error. No state changes.
- almost_full and almost_empty are combinational compares on the count register.
- reset or clear: wr_ptr, rd_ptr, ram_count and count go to 0, out_valid goes to 0. Any push or pop in that same cycle is discarded. RAM contents are not cleared.
- Reset values: in_ready 1, out_valid 0, count 0, almost_full 0, almost_empty 1 (for AE_THRESH >= 0). out_data is don't-care while out_valid is 0. The RAM q has no reset.

## Timing
- Write latency: push in cycle 0 into an empty FIFO gives out_valid = 1 with that word on out_data in cycle 2.
- Throughput: with in_valid and out_ready held high, one push and one pop occur every cycle in steady state.
- Same-address read-during-write cannot occur: a read is issued only for words already counted in ram_count, i.e. written at an earlier edge.
- Pointer wrap: the pointers are ADDR_W bits and wrap naturally. count holds DEPTH without aliasing.
- Stall: while out_valid && !out_ready, out_data and out_valid stay constant.

## Structure
- Shared package m10k_pkg:
  - M10K_BITS = 10240 constant
  - a helper giving the number of M10K blocks used for a given DATA_W/ADDR_W
- Sub-module m10k_sdp_ram (parameters DATA_W, ADDR_W):
  - one clk, write port (we, wr_addr, d), read port (rd_en, rd_addr)
  - registered q updates only on rd_en; 1-cycle read latency
  - synthesis ramstyle "no_rw_check, M10K"
  - no reset on memory or q
- The FIFO top holds pointers, counters, out_valid and the flag logic.

## Test plan
- Reset, then single push of 0xA5A5_0001 in cycle 0 with out_ready = 0:
  - cycles 0-1: out_valid 0
  - cycle 2 onward: out_valid 1, out_data 0xA5A5_0001 held; count 1
- Fill with DEPTH = 256 words 0..255, out_ready = 0:
  - in_ready drops after the 256th push; count 256, almost_full 1
  - word 256 is not written and count stays 256
- Drain the full FIFO with out_ready = 1:
  - outputs 0..255 in order, one per cycle
  - almost_empty rises when count <= 4; out_valid 0 after the last word; count 0
- Streaming 1000 words with out_ready toggling on a pseudo-random pattern and in_valid high:
  - output sequence equals input sequence, checked across multiple pointer wraps
  - out_data stable during stalls
- Full FIFO, in_valid = 1 and out_ready = 1 in the same cycle:
  - pop occurs, push refused, count goes 256 -> 255
  - next cycle the push is accepted
- Assert clear mid-stream with count = 37 while a push and a pop are also presented:
  - next cycle count 0, out_valid 0, in_ready 1
  - a subsequent push of 0x1234 appears at the head 2 cycles later

Source files
------------

// File: rtl/m10k_pkg.sv
// rtl/m10k_pkg.sv - shared M10K constants and block-count helper
package m10k_pkg;

  localparam int M10K_BITS = 10240;

  // Rounds up: a partially used block still occupies a whole M10K.
  function automatic int m10k_blocks(input int data_w, input int addr_w);
    return (data_w * (1 << addr_w) + M10K_BITS - 1) / M10K_BITS;
  endfunction

endpackage

// File: rtl/m10k_sdp_ram.sv
// rtl/m10k_sdp_ram.sv - simple-dual-port M10K with registered, read-enabled q
module m10k_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] d,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] q
);

  (* ramstyle = "no_rw_check, M10K" *) logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // No reset on mem or q so the block maps onto M10K hard RAM.
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= d;
    if (rd_en)
      q <= mem[rd_addr];
  end

endmodule

// File: rtl/m10k_fifo.sv
// rtl/m10k_fifo.sv - first-word-fall-through FIFO on one M10K, q register as output stage
module m10k_fifo
  import m10k_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int AF_THRESH = (1 << ADDR_W) - 4,
  parameter int AE_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   ram_count;
  logic              flush, push, pop, rd_en;

  assign flush    = reset || clear;
  assign in_ready = (count != DEPTH_C);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign rd_en    = (ram_count != '0) && (!out_valid || out_ready) && !flush;

  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  m10k_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .d       (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .q       (out_data)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push, rd_en})
        2'b10:   ram_count <= ram_count + 1'b1;
        2'b01:   ram_count <= ram_count - 1'b1;
        default: ram_count <= ram_count;
      endcase

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (rd_en)
        out_valid <= 1'b1;
      else if (pop)
        out_valid <= 1'b0;
    end
  end

endmodule
